// File: rtl/buffer_fifo_pkg.sv
// Shared types and default sizes for the chunked sample FIFO and its sequencing controller.
package buffer_fifo_pkg;

    localparam int unsigned DefSampleSize = 24;
    localparam int unsigned DefIoBuffSize = 64;
    localparam int unsigned DefFifoDepth  = 16;

    typedef enum logic {
        W_FILL,
        W_DONE
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_VALID
    } rd_state_e;

endpackage

// File: rtl/buffer_fifo_ctrl_if.sv
// Upstream and downstream sample valid/ready streams of buffer_fifo_ctrl.
interface buffer_fifo_ctrl_if
    import buffer_fifo_pkg::*;
#(
    parameter int unsigned SAMPLE_SIZE = DefSampleSize
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [SAMPLE_SIZE-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [SAMPLE_SIZE-1:0] out_data;

    // Sample producer / consumer side.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Controller side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/buffer_fifo_ctrl.sv
// Write/read sequencing and chunk occupancy tracking for buffer_fifo.
// Optional BUFFER_FIFO_CTRL_STATS_EN adds overrun and high-water statistics ports.
module buffer_fifo_ctrl
    import buffer_fifo_pkg::*;
#(
    parameter int unsigned SAMPLE_SIZE      = DefSampleSize,
    parameter int unsigned IO_BUFF_SIZE     = DefIoBuffSize,
    parameter int unsigned IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE),
    parameter int unsigned FIFO_DEPTH       = DefFifoDepth,
    parameter int unsigned FIFO_PTR_BITS    = $clog2(FIFO_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    buffer_fifo_ctrl_if.slave           bus,
    output logic                        fill_o,
    output logic                        fill_done_o,
    output logic                        read_o,
    output logic                        read_done_o,
    output logic [SAMPLE_SIZE-1:0]      write_sample_o,
    output logic [IO_BUFF_PTR_BITS-1:0] write_ptr_o,
    output logic [IO_BUFF_PTR_BITS-1:0] read_ptr_o,
    input  logic [SAMPLE_SIZE-1:0]      read_sample_i,
    output logic [FIFO_PTR_BITS:0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
`ifdef BUFFER_FIFO_CTRL_STATS_EN
    ,
    input  logic                        stats_clr_i,
    output logic                        overrun_o,
    output logic [FIFO_PTR_BITS:0]      high_water_o
`endif
);

    localparam logic [IO_BUFF_PTR_BITS-1:0] LastPtr  = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);
    localparam logic [FIFO_PTR_BITS:0]      DepthCnt = (FIFO_PTR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_PTR_BITS:0]      OneCnt   = (FIFO_PTR_BITS + 1)'(1);

    wr_state_e                   wr_state_q, wr_state_d;
    rd_state_e                   rd_state_q, rd_state_d;
    logic [IO_BUFF_PTR_BITS-1:0] wptr_q, wptr_d;
    logic [IO_BUFF_PTR_BITS-1:0] rptr_q, rptr_d;
    logic [SAMPLE_SIZE-1:0]      out_data_q, out_data_d;
    logic [FIFO_PTR_BITS:0]      count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_FILL;
            rd_state_q <= R_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            out_data_q <= '0;
            count_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            out_data_q <= out_data_d;
            count_q    <= count_d;
        end
    end

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Write side outputs; in_ready is gated by rst_n so nothing is accepted during reset.
    always_comb begin
        bus.in_ready   = 1'b0;
        fill_o         = 1'b0;
        fill_done_o    = 1'b0;
        write_sample_o = bus.in_data;
        write_ptr_o    = wptr_q;
        unique case (wr_state_q)
            W_FILL: begin
                bus.in_ready = !full_o && rst_n;
                fill_o       = bus.in_ready && bus.in_valid;
            end
            W_DONE: fill_done_o = 1'b1;
            default: ;
        endcase
    end

    // fill_done gets its own cycle so the FIFO never switches chunks during the last write.
    always_comb begin
        wr_state_d = wr_state_q;
        wptr_d     = wptr_q;
        unique case (wr_state_q)
            W_FILL: begin
                if (fill_o) begin
                    wptr_d = wptr_q + 1'b1;
                    if (wptr_q == LastPtr) begin
                        wr_state_d = W_DONE;
                    end
                end
            end
            W_DONE: begin
                wptr_d     = '0;
                wr_state_d = W_FILL;
            end
            default: wr_state_d = W_FILL;
        endcase
    end

    always_comb begin
        read_o        = (rd_state_q == R_FETCH);
        read_ptr_o    = rptr_q;
        bus.out_valid = (rd_state_q == R_VALID);
        bus.out_data  = out_data_q;
        read_done_o   = (rd_state_q == R_VALID) && bus.out_ready && (rptr_q == LastPtr);
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rptr_d     = rptr_q;
        out_data_d = out_data_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (!empty_o) begin
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                out_data_d = read_sample_i;
                rd_state_d = R_VALID;
            end
            R_VALID: begin
                if (bus.out_ready) begin
                    if (rptr_q == LastPtr) begin
                        rptr_d     = '0;
                        rd_state_d = (count_q > OneCnt) ? R_FETCH : R_IDLE;
                    end else begin
                        rptr_d     = rptr_q + 1'b1;
                        rd_state_d = R_FETCH;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // A coincident fill_done and read_done cancel out.
    always_comb begin
        count_d = count_q;
        unique case ({fill_done_o, read_done_o})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef BUFFER_FIFO_CTRL_STATS_EN
    logic                   overrun_q, overrun_d;
    logic [FIFO_PTR_BITS:0] high_water_q, high_water_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q    <= 1'b0;
            high_water_q <= '0;
        end else begin
            overrun_q    <= overrun_d;
            high_water_q <= high_water_d;
        end
    end

    // Clear first so that a coincident set condition wins.
    always_comb begin
        overrun_d    = stats_clr_i ? 1'b0 : overrun_q;
        high_water_d = stats_clr_i ? count_q : high_water_q;
        if (bus.in_valid && full_o) begin
            overrun_d = 1'b1;
        end
        if (count_q > high_water_d) begin
            high_water_d = count_q;
        end
    end

    assign overrun_o    = overrun_q;
    assign high_water_o = high_water_q;
`endif

endmodule

// File: tb/tb_buffer_fifo_ctrl.sv
// Directed self-checking bench for buffer_fifo_ctrl with a behavioural chunk FIFO model.
module tb_buffer_fifo_ctrl;
    import buffer_fifo_pkg::*;

    localparam int SW = 24;
    localparam int BS = 64;
    localparam int PB = 6;
    localparam int FD = 16;
    localparam int FB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    buffer_fifo_ctrl_if #(.SAMPLE_SIZE(SW)) bus ();

    logic          fill, fill_done, rd, read_done, full, empty;
    logic [SW-1:0] write_sample, read_sample;
    logic [PB-1:0] write_ptr, read_ptr;
    logic [FB:0]   count;
`ifdef BUFFER_FIFO_CTRL_STATS_EN
    logic          stats_clr, overrun;
    logic [FB:0]   high_water;
`endif

    buffer_fifo_ctrl #(
        .SAMPLE_SIZE      (SW),
        .IO_BUFF_SIZE     (BS),
        .IO_BUFF_PTR_BITS (PB),
        .FIFO_DEPTH       (FD),
        .FIFO_PTR_BITS    (FB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .fill_o         (fill),
        .fill_done_o    (fill_done),
        .read_o         (rd),
        .read_done_o    (read_done),
        .write_sample_o (write_sample),
        .write_ptr_o    (write_ptr),
        .read_ptr_o     (read_ptr),
        .read_sample_i  (read_sample),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty)
`ifdef BUFFER_FIFO_CTRL_STATS_EN
        ,
        .stats_clr_i    (stats_clr),
        .overrun_o      (overrun),
        .high_water_o   (high_water)
`endif
    );

    // Chunk FIFO model: head/tail advance on the done strobes, read data lands on the falling edge.
    logic [SW-1:0] mem [FD][BS];
    int            whead, rtail;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            whead <= 0;
            rtail <= 0;
        end else begin
            if (fill) mem[whead][write_ptr] <= write_sample;
            if (fill_done) whead <= (whead + 1) % FD;
            if (read_done) rtail <= (rtail + 1) % FD;
        end
    end
    always @(negedge clk) begin
        if (rd) read_sample <= mem[rtail][read_ptr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;
    int wr_chunk = 0, wr_idx = 0, rd_chunk = 0, rd_idx = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] smp(input int c, input int i);
        return SW'(c * 256 + i);
    endfunction

    // Starts and ends at a falling edge; in_valid is held until each sample is accepted.
    task automatic push(input int n);
        int k = 0;
        int budget = 400;
        while (k < n) begin
            bus.in_valid = 1'b1;
            bus.in_data  = smp(wr_chunk, wr_idx);
            #1;
            if (bus.in_ready) begin
                check_eq("fill", 32'(fill), 32'd1);
                check_eq("write_ptr", 32'(write_ptr), 32'(wr_idx));
                check_eq("write_sample", 32'(write_sample), 32'(smp(wr_chunk, wr_idx)));
                wr_idx++;
                if (wr_idx == BS) begin
                    wr_idx = 0;
                    wr_chunk++;
                end
                k++;
                budget = 400;
            end else begin
                budget--;
                if (budget == 0) begin
                    check_eq("push_timeout", 32'(k), 32'(n));
                    break;
                end
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pull(input int n, input bit rate);
        int k = 0;
        int budget = 400;
        int last = -1;
        while (k < n) begin
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                check_eq("out_data", 32'(bus.out_data), 32'(smp(rd_chunk, rd_idx)));
                check_eq("read_done", 32'(read_done), 32'(rd_idx == BS - 1));
                if (rate && last >= 0) check_eq("out_rate", 32'(cyc - last), 32'd2);
                last = cyc;
                rd_idx++;
                if (rd_idx == BS) begin
                    rd_idx = 0;
                    rd_chunk++;
                end
                k++;
                budget = 400;
            end else begin
                budget--;
                if (budget == 0) begin
                    check_eq("pull_timeout", 32'(k), 32'(n));
                    break;
                end
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef BUFFER_FIFO_CTRL_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_fill", 32'(fill), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Single chunk fill, then hold in_valid through the fill_done bubble.
        @(negedge clk);
        push(BS);
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h55;
        #1;
        check_eq("wdone_fill_done", 32'(fill_done), 32'd1);
        check_eq("wdone_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("wdone_fill", 32'(fill), 32'd0);
        check_eq("wdone_count", 32'(count), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check_eq("commit_count", 32'(count), 32'd1);
        check_eq("commit_fill_done", 32'(fill_done), 32'd0);
        check_eq("commit_empty", 32'(empty), 32'd0);

        // Drain at one sample per two cycles.
        @(negedge clk);
        pull(BS, 1'b1);
        #1;
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_empty", 32'(empty), 32'd1);
        check_eq("drain_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1;
        check_eq("idle_read", 32'(rd), 32'd0);
        check_eq("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Fill to full with the consumer stalled.
        @(negedge clk);
        push(FD * BS);
        bus.in_valid = 1'b1;
        @(negedge clk);
        #1;
        check_eq("full_count", 32'(count), 32'(FD));
        check_eq("full_full", 32'(full), 32'd1);
        check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("full_fill", 32'(fill), 32'd0);
        @(negedge clk);
        #1;
        check_eq("full_held_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef BUFFER_FIFO_CTRL_STATS_EN
        check_eq("overrun_set", 32'(overrun), 32'd1);
        check_eq("high_water_16", 32'(high_water), 32'(FD));
`endif
        bus.in_valid = 1'b0;
        @(negedge clk);
        pull(BS, 1'b0);
        #1;
        check_eq("unfull_count", 32'(count), 32'(FD - 1));
        check_eq("unfull_full", 32'(full), 32'd0);
        check_eq("unfull_in_ready", 32'(bus.in_ready), 32'd1);

        // Drain to three chunks, then align fill_done with read_done.
        @(negedge clk);
        pull(12 * BS, 1'b0);
        #1;
        check_eq("three_count", 32'(count), 32'd3);
        @(negedge clk);
        pull(BS - 1, 1'b0);
        push(BS - 1);
        push(1);
        bus.out_ready = 1'b1;
        #1;
        check_eq("sim_fill_done", 32'(fill_done), 32'd1);
        check_eq("sim_read_done", 32'(read_done), 32'd1);
        check_eq("sim_out_data", 32'(bus.out_data), 32'(smp(rd_chunk, rd_idx)));
        rd_idx = 0;
        rd_chunk++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check_eq("sim_count", 32'(count), 32'd3);

`ifdef BUFFER_FIFO_CTRL_STATS_EN
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        check_eq("clr_overrun", 32'(overrun), 32'd0);
        check_eq("clr_high_water", 32'(high_water), 32'd3);
`endif

        // Reset partway through a chunk.
        @(negedge clk);
        push(10);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        check_eq("mid_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("mid_fill", 32'(fill), 32'd0);
        check_eq("mid_fill_done", 32'(fill_done), 32'd0);
        check_eq("mid_read", 32'(rd), 32'd0);
        check_eq("mid_read_done", 32'(read_done), 32'd0);
        check_eq("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_out_data", 32'(bus.out_data), 32'd0);
        check_eq("mid_write_ptr", 32'(write_ptr), 32'd0);
        check_eq("mid_read_ptr", 32'(read_ptr), 32'd0);
        check_eq("mid_count", 32'(count), 32'd0);
        check_eq("mid_empty", 32'(empty), 32'd1);
        check_eq("mid_full", 32'(full), 32'd0);
`ifdef BUFFER_FIFO_CTRL_STATS_EN
        check_eq("mid_overrun", 32'(overrun), 32'd0);
        check_eq("mid_high_water", 32'(high_water), 32'd0);
`endif
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        wr_chunk = 100;
        wr_idx   = 0;
        rd_chunk = 100;
        rd_idx   = 0;
        push(BS);
        pull(BS, 1'b0);
        #1;
        check_eq("post_count", 32'(count), 32'd0);
        check_eq("post_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
